id_decode_stage: RTL and testbench

- Instruction-decode pipeline stage sitting between instruction fetch and the immediate generator / register file read.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Decodes each word into register indices, function fields, a 12-bit raw immediate and an immediate-select strobe, which feed the immediate generator (sel, data_imm).
- Sustains full throughput under backpressure with 1-cycle latency.

---
 rtl/id_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_id_decode_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: 2-entry skid buffer feeding combinational field/immediate decode.
// Optional macro ID_ILLEGAL_DETECT_EN enables illegal-opcode flagging on out_illegal.
module id_decode_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [11:0]     out_imm12,
  output logic            out_imm_sel,
  output logic            out_imm_b,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic [XLEN-1:0]   main_inst_q, main_inst_d, main_pc_q, main_pc_d;
  logic [XLEN-1:0]   skid_inst_q, skid_inst_d, skid_pc_q, skid_pc_d;
  logic              accept, consume;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = ONE;
          main_inst_d = in_inst;
          main_pc_d   = in_pc;
        end
        ONE: begin
          if (accept && consume) begin
            main_inst_d = in_inst;
            main_pc_d   = in_pc;
          end else if (accept) begin
            state_d     = TWO;
            skid_inst_d = in_inst;
            skid_pc_d   = in_pc;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: if (consume) begin
          state_d     = ONE;
          main_inst_d = skid_inst_q;
          main_pc_d   = skid_pc_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_inst_q <= '0;
      main_pc_q   <= RESET_PC;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  logic illegal;

`ifdef ID_ILLEGAL_DETECT_EN
  logic legal_op;
  always_comb begin
    legal_op = 1'b0;
    unique case (main_inst_q[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end
  assign illegal = out_valid & (~legal_op | (main_inst_q[1:0] != 2'b11));
`else
  assign illegal = 1'b0;
`endif

  assign out_pc      = main_pc_q;
  assign out_opcode  = main_inst_q[6:0];
  assign out_rd      = illegal ? 5'd0 : main_inst_q[11:7];
  assign out_funct3  = main_inst_q[14:12];
  assign out_rs1     = main_inst_q[19:15];
  assign out_rs2     = main_inst_q[24:20];
  assign out_funct7  = main_inst_q[31:25];
  assign out_illegal = illegal;

  // Shift-immediates pass inst[31:20] untouched; shamt masking happens downstream.
  always_comb begin
    out_imm12   = 12'd0;
    out_imm_sel = 1'b0;
    out_imm_b   = 1'b0;
    unique case (main_inst_q[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        out_imm12   = main_inst_q[31:20];
        out_imm_sel = 1'b1;
      end
      OP_STORE: begin
        out_imm12   = {main_inst_q[31:25], main_inst_q[11:7]};
        out_imm_sel = 1'b1;
      end
      OP_BRANCH: begin
        out_imm12   = {main_inst_q[31], main_inst_q[7], main_inst_q[30:25], main_inst_q[11:8]};
        out_imm_sel = 1'b1;
        out_imm_b   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed self-checking bench for id_decode_stage: decode fields, skid backpressure, flush, reset.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7, out_opcode;
  logic [11:0] out_imm12;
  logic        out_imm_sel, out_imm_b, out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_opcode(out_opcode), .out_imm12(out_imm12),
    .out_imm_sel(out_imm_sel), .out_imm_b(out_imm_b), .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  // Present one word with out_ready=1; returns one cycle after acceptance.
  task automatic send_one(input logic [31:0] inst, input logic [31:0] pc);
    out_ready = 1'b1;
    drive(1'b1, inst, pc);
    tick();
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%0b exp=0", in_ready); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b exp=0", out_valid); errors++; end
    checks++; if (out_pc !== 32'h0) begin $display("FAIL reset_out_pc got=%h exp=00000000", out_pc); errors++; end
    checks++; if ({out_imm12, out_imm_sel, out_imm_b, out_illegal, out_rd} !== 20'h0) begin
      $display("FAIL reset_outputs got=%h exp=0", {out_imm12, out_imm_sel, out_imm_b, out_illegal, out_rd}); errors++; end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_release_valid got=%0b exp=0", out_valid); errors++; end
  endtask

  task automatic test_itype();
    send_one(32'hFFB0_0093, 32'h100);
    checks++; if (out_valid !== 1'b1) begin $display("FAIL addi_valid got=%0b exp=1", out_valid); errors++; end
    checks++; if (out_imm12 !== 12'hFFB) begin $display("FAIL addi_imm got=%h exp=ffb", out_imm12); errors++; end
    checks++; if (out_imm_sel !== 1'b1 || out_imm_b !== 1'b0) begin $display("FAIL addi_sel got=%0b%0b exp=10", out_imm_sel, out_imm_b); errors++; end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", out_rd, out_rs1); errors++; end
    checks++; if (out_pc !== 32'h100) begin $display("FAIL addi_pc got=%h exp=00000100", out_pc); errors++; end
    tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL addi_drain got=%0b exp=0", out_valid); errors++; end
  endtask

  task automatic test_stype();
    send_one(32'h0020_A423, 32'h104);
    checks++; if (out_imm12 !== 12'h008 || out_imm_sel !== 1'b1) begin $display("FAIL sw_imm got=%h/%0b exp=008/1", out_imm12, out_imm_sel); errors++; end
    checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin $display("FAIL sw_regs got rs1=%0d rs2=%0d exp rs1=1 rs2=2", out_rs1, out_rs2); errors++; end
    checks++; if (out_funct3 !== 3'b010 || out_opcode !== 7'b0100011) begin $display("FAIL sw_fields got f3=%b op=%b exp f3=010 op=0100011", out_funct3, out_opcode); errors++; end
    tick();
  endtask

  task automatic test_btype_rtype();
    send_one(32'hFE00_0EE3, 32'h108);
    checks++; if (out_imm12 !== 12'hFFE) begin $display("FAIL beq_imm got=%h exp=ffe", out_imm12); errors++; end
    checks++; if (out_imm_b !== 1'b1 || out_imm_sel !== 1'b1) begin $display("FAIL beq_sel got b=%0b sel=%0b exp b=1 sel=1", out_imm_b, out_imm_sel); errors++; end
    tick();
    send_one(32'h0020_81B3, 32'h10C);
    checks++; if (out_imm_sel !== 1'b0 || out_imm12 !== 12'h000 || out_imm_b !== 1'b0) begin
      $display("FAIL add_imm got sel=%0b imm=%h b=%0b exp sel=0 imm=000 b=0", out_imm_sel, out_imm12, out_imm_b); errors++; end
    checks++; if (out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      $display("FAIL add_regs got rd=%0d rs1=%0d rs2=%0d exp 3 1 2", out_rd, out_rs1, out_rs2); errors++; end
    checks++; if (out_funct7 !== 7'd0 || out_illegal !== 1'b0) begin $display("FAIL add_f7 got f7=%h ill=%0b exp 0 0", out_funct7, out_illegal); errors++; end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h200);
    tick();
    drive(1'b1, 32'h0010_0093, 32'h204);
    tick();
    drive(1'b1, 32'h0020_0113, 32'h208);
    checks++; if (in_ready !== 1'b0) begin $display("FAIL b2b_full_ready got=%0b exp=0", in_ready); errors++; end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin $display("FAIL b2b_hold got v=%0b pc=%h exp v=1 pc=00000200", out_valid, out_pc); errors++; end
    checks++; if (in_ready !== 1'b0) begin $display("FAIL b2b_still_full got=%0b exp=0", in_ready); errors++; end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_imm12 !== 12'h001) begin
      $display("FAIL b2b_second got v=%0b pc=%h imm=%h exp v=1 pc=00000204 imm=001", out_valid, out_pc, out_imm12); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL b2b_reopen got=%0b exp=1", in_ready); errors++; end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_imm12 !== 12'h002) begin
      $display("FAIL b2b_third got v=%0b pc=%h imm=%h exp v=1 pc=00000208 imm=002", out_valid, out_pc, out_imm12); errors++; end
    tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain got=%0b exp=0", out_valid); errors++; end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h300);
    tick();
    drive(1'b1, 32'h0000_0013, 32'h304);
    tick();
    drive(1'b1, 32'h0000_0013, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_valid got=%0b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL flush_ready got=%0b exp=1", in_ready); errors++; end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_ghost%0d got v=%0b pc=%h exp v=0", i, out_valid, out_pc); errors++; end
    end
    // Accept in ONE concurrent with flush: the new word is dropped too.
    send_one(32'h0000_0013, 32'h30C);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h310);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_one_drop got v=%0b pc=%h exp v=0", out_valid, out_pc); errors++; end
  endtask

  task automatic test_illegal();
    send_one(32'h0000_007F, 32'h400);
`ifdef ID_ILLEGAL_DETECT_EN
    checks++; if (out_illegal !== 1'b1 || out_rd !== 5'd0) begin $display("FAIL ill_7f got ill=%0b rd=%0d exp ill=1 rd=0", out_illegal, out_rd); errors++; end
`else
    checks++; if (out_illegal !== 1'b0) begin $display("FAIL ill_7f got ill=%0b exp ill=0", out_illegal); errors++; end
`endif
    checks++; if (out_imm_sel !== 1'b0 || out_valid !== 1'b1) begin $display("FAIL ill_7f_sel got sel=%0b v=%0b exp sel=0 v=1", out_imm_sel, out_valid); errors++; end
    tick();
    send_one(32'h0000_0FFF, 32'h404);
`ifdef ID_ILLEGAL_DETECT_EN
    checks++; if (out_illegal !== 1'b1 || out_rd !== 5'd0) begin $display("FAIL ill_fff got ill=%0b rd=%0d exp ill=1 rd=0", out_illegal, out_rd); errors++; end
`else
    checks++; if (out_illegal !== 1'b0 || out_rd !== 5'd31) begin $display("FAIL ill_fff got ill=%0b rd=%0d exp ill=0 rd=31", out_illegal, out_rd); errors++; end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h500);
    tick();
    drive(1'b1, 32'h0000_0013, 32'h504);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_async_valid got=%0b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h0) begin $display("FAIL rst_async_state got rdy=%0b pc=%h exp rdy=0 pc=00000000", in_ready, out_pc); errors++; end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL rst_after got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); errors++; end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_stype();
    test_btype_rtype();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
